// File: rtl/hht_col_dot_ctrl_if.sv
// hht_col_dot_ctrl_if: request, memory-port and result signals of the column dot-product controller
interface hht_col_dot_ctrl_if #(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int ACCW = 64,
  parameter int LENW = 16
);
  logic            start_i;
  logic [AW-1:0]   v_base_i;
  logic [AW-1:0]   col_base_i;
  logic [LENW-1:0] csize_i;
  logic [LENW-1:0] col_stride_i;
  logic [LENW-1:0] ncols_i;
  logic [AW-1:0]   addr1_o;
  logic [AW-1:0]   addr2_o;
  logic [DW-1:0]   data_in1_i;
  logic [DW-1:0]   data_in2_i;
  logic [ACCW-1:0] res_o;
  logic [LENW-1:0] res_col_o;
  logic            res_valid_o;
  logic            res_ready_i;
  logic            busy_o;
  logic            done_o;
  modport slave (
    input  start_i, v_base_i, col_base_i, csize_i, col_stride_i, ncols_i,
    input  data_in1_i, data_in2_i, res_ready_i,
    output addr1_o, addr2_o, res_o, res_col_o, res_valid_o, busy_o, done_o
  );
  modport master (
    output start_i, v_base_i, col_base_i, csize_i, col_stride_i, ncols_i,
    output data_in1_i, data_in2_i, res_ready_i,
    input  addr1_o, addr2_o, res_o, res_col_o, res_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/hht_col_dot_ctrl.sv
// hht_col_dot_ctrl: streams a vector and NCOLS matrix columns and emits one dot product per column
module hht_col_dot_ctrl #(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int ACCW   = 64,
  parameter int LENW   = 16,
  parameter bit SIGNED = 1'b0
) (
  input logic clk,
  input logic rst,
  hht_col_dot_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, OUT, DONE} state_t;
  state_t          state_q;
  logic [AW-1:0]   vb_q, colptr_q, a1_q, a2_q;
  logic [LENW-1:0] csz_q, str_q, nc_q, i_q, c_q, res_col_q;
  logic [ACCW-1:0] acc_q, res_q;
  logic            res_valid_q, busy_q, done_q;
  logic [AW-1:0]   addr1_d, addr2_d;
  logic [ACCW-1:0] sum_d;
  function automatic logic [ACCW-1:0] ext(input logic [DW-1:0] x);
    return SIGNED ? {{(ACCW-DW){x[DW-1]}}, x} : {{(ACCW-DW){1'b0}}, x};
  endfunction
  assign addr1_d = colptr_q + AW'(i_q);
  assign addr2_d = vb_q + AW'(i_q);
  assign sum_d   = acc_q + ext(bus.data_in1_i) * ext(bus.data_in2_i);
  // live addresses while streaming, last streamed address held while waiting, zero when idle
  assign bus.addr1_o     = state_q == RUN ? addr1_d : (state_q == IDLE ? '0 : a1_q);
  assign bus.addr2_o     = state_q == RUN ? addr2_d : (state_q == IDLE ? '0 : a2_q);
  assign bus.res_o       = res_q;
  assign bus.res_col_o   = res_col_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  // control FSM: latch job, accumulate one element per cycle, hand off each column result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vb_q        <= '0;
      colptr_q    <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      csz_q       <= '0;
      str_q       <= '0;
      nc_q        <= '0;
      i_q         <= '0;
      c_q         <= '0;
      res_col_q   <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start_i) begin
          vb_q      <= bus.v_base_i;
          colptr_q  <= bus.col_base_i;
          csz_q     <= bus.csize_i;
          str_q     <= bus.col_stride_i;
          nc_q      <= bus.ncols_i;
          acc_q     <= '0;
          i_q       <= '0;
          c_q       <= '0;
          a1_q      <= '0;
          a2_q      <= '0;
          res_q     <= '0;
          res_col_q <= '0;
          if (bus.ncols_i == '0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            busy_q      <= 1'b1;
            res_valid_q <= bus.csize_i == '0;
            state_q     <= bus.csize_i == '0 ? OUT : RUN;
          end
        end
        RUN: begin
          acc_q <= sum_d;
          i_q   <= i_q + 1'b1;
          a1_q  <= addr1_d;
          a2_q  <= addr2_d;
          if (i_q == csz_q - 1'b1) begin
            res_q       <= sum_d;
            res_col_q   <= c_q;
            res_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: if (bus.res_ready_i) begin
          if (c_q == nc_q - 1'b1) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else begin
            c_q      <= c_q + 1'b1;
            colptr_q <= colptr_q + AW'(str_q);
            acc_q    <= '0;
            i_q      <= '0;
            if (csz_q == '0) begin
              res_q     <= '0;
              res_col_q <= c_q + 1'b1;
            end else begin
              res_valid_q <= 1'b0;
              state_q     <= RUN;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hht_col_dot_ctrl.sv
// tb_hht_col_dot_ctrl: randomized self-checking bench against a dot-product reference model
module tb_hht_col_dot_ctrl;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  logic [31:0] sdat1, sdat2;
  always #5 clk = ~clk;
  hht_col_dot_ctrl_if #(.DW(32), .AW(32), .ACCW(64), .LENW(16)) bus ();
  hht_col_dot_ctrl_if #(.DW(32), .AW(32), .ACCW(64), .LENW(16)) bus_s ();
  hht_col_dot_ctrl #(.DW(32), .AW(32), .ACCW(64), .LENW(16), .SIGNED(1'b0)) u_dut (.clk(clk), .rst(rst), .bus(bus));
  hht_col_dot_ctrl #(.DW(32), .AW(32), .ACCW(64), .LENW(16), .SIGNED(1'b1)) u_dut_s (.clk(clk), .rst(rst), .bus(bus_s));
  assign bus.data_in1_i   = mem1[bus.addr1_o[7:0]];
  assign bus.data_in2_i   = mem2[bus.addr2_o[7:0]];
  assign bus_s.data_in1_i = sdat1;
  assign bus_s.data_in2_i = sdat2;
  function automatic logic [63:0] ext(input logic [31:0] x, input bit s);
    return s ? {{32{x[31]}}, x} : {32'd0, x};
  endfunction
  task automatic clear_mem();
    for (int k = 0; k < 256; k++) begin
      mem1[k] = '0;
      mem2[k] = '0;
    end
  endtask
  task automatic load_s1();
    clear_mem();
    mem2[2] = 55; mem2[3] = 1; mem2[4] = 0;
    mem1[180] = 0; mem1[181] = 5; mem1[182] = 7;
    mem1[183] = 10; mem1[184] = 6; mem1[185] = 9;
  endtask
  // Runs one job on the unsigned DUT, checking results, holds, addresses and done timing.
  task automatic run_job(input logic [31:0] vb, input logic [31:0] cb, input logic [15:0] cs,
                         input logic [15:0] st, input logic [15:0] nc, input int stall_pct,
                         input int first_stall, input bit noisy);
    logic [63:0] expq [$];
    logic [63:0] s, hres;
    logic [31:0] a, b, ha1, ha2;
    logic [15:0] hcol;
    int n, stalls, got, held, first_n;
    bit was_stall, done_seen, rdy;
    for (int c = 0; c < int'(nc); c++) begin
      s = '0;
      for (int i = 0; i < int'(cs); i++) begin
        a = cb + 32'(c) * 32'(st) + 32'(i);
        b = vb + 32'(i);
        s = s + ext(mem1[a[7:0]], 1'b0) * ext(mem2[b[7:0]], 1'b0);
      end
      expq.push_back(s);
    end
    n = 0; stalls = 0; got = 0; held = 0; first_n = -1;
    was_stall = 0; done_seen = 0;
    hres = '0; hcol = '0; ha1 = '0; ha2 = '0;
    @(negedge clk);
    bus.v_base_i = vb; bus.col_base_i = cb; bus.csize_i = cs;
    bus.col_stride_i = st; bus.ncols_i = nc; bus.start_i = 1'b1; bus.res_ready_i = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.v_base_i = $urandom; bus.col_base_i = $urandom; bus.csize_i = 16'($urandom);
    bus.col_stride_i = 16'($urandom); bus.ncols_i = 16'($urandom);
    while (n < 4000) begin
      if (bus.done_o) begin
        done_seen = 1;
        break;
      end
      checks++;
      if (bus.busy_o !== 1'b1) begin
        errors++;
        $display("FAIL busy n=%0d: got %b exp 1", n, bus.busy_o);
      end
      if (bus.res_valid_o) begin
        if (first_n < 0) begin
          first_n = n;
          if (cs != 0) begin
            checks++;
            if (first_n != int'(cs)) begin
              errors++;
              $display("FAIL first_valid: got cycle %0d exp %0d", first_n, cs);
            end
          end
        end
        if (was_stall) begin
          checks++;
          if (bus.res_o !== hres || bus.res_col_o !== hcol || bus.addr1_o !== ha1 || bus.addr2_o !== ha2) begin
            errors++;
            $display("FAIL hold: got res %h col %0d a1 %h a2 %h exp res %h col %0d a1 %h a2 %h",
                     bus.res_o, bus.res_col_o, bus.addr1_o, bus.addr2_o, hres, hcol, ha1, ha2);
          end
        end else begin
          checks++;
          if (got >= expq.size() || bus.res_o !== expq[got] || bus.res_col_o !== 16'(got)) begin
            errors++;
            $display("FAIL result #%0d: got res %h col %0d exp res %h col %0d", got, bus.res_o,
                     bus.res_col_o, got < expq.size() ? expq[got] : 64'hx, got);
          end
          if (cs != 0) begin
            a = cb + 32'(got) * 32'(st) + 32'(cs) - 32'd1;
            b = vb + 32'(cs) - 32'd1;
            checks++;
            if (bus.addr1_o !== a || bus.addr2_o !== b) begin
              errors++;
              $display("FAIL addr col %0d: got %h/%h exp %h/%h", got, bus.addr1_o, bus.addr2_o, a, b);
            end
          end
          hres = bus.res_o; hcol = bus.res_col_o; ha1 = bus.addr1_o; ha2 = bus.addr2_o;
          held = 0;
        end
        rdy = (got == 0 && held < first_stall) ? 1'b0 : ($urandom_range(99) >= stall_pct);
        bus.res_ready_i = rdy;
        if (rdy) begin
          got++;
          was_stall = 0;
        end else begin
          held++;
          stalls++;
          was_stall = 1;
        end
      end else begin
        bus.res_ready_i = 1'($urandom_range(1));
        was_stall = 0;
      end
      if (noisy) bus.start_i = 1'($urandom_range(1));
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles exp done", n);
    end else begin
      checks++;
      if (got != int'(nc) || n != int'(nc) * (int'(cs) + 1) + stalls || bus.busy_o !== 1'b0) begin
        errors++;
        $display("FAIL done: got results %0d cycle %0d busy %b exp results %0d cycle %0d busy 0",
                 got, n, bus.busy_o, nc, int'(nc) * (int'(cs) + 1) + stalls);
      end
    end
    bus.res_ready_i = 1'b1;
    bus.start_i = noisy;
    @(negedge clk);
    bus.start_i = 1'b0;
    checks++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.res_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL after_done: got done %b busy %b valid %b exp 0 0 0", bus.done_o, bus.busy_o, bus.res_valid_o);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.addr1_o, bus.addr2_o, bus.res_o, bus.res_col_o, bus.res_valid_o, bus.busy_o, bus.done_o} !== '0 ||
        {bus_s.res_valid_o, bus_s.busy_o, bus_s.done_o, bus_s.res_o} !== '0) begin
      errors++;
      $display("FAIL reset: got a1 %h a2 %h res %h col %0d v %b b %b d %b exp all 0", bus.addr1_o, bus.addr2_o,
               bus.res_o, bus.res_col_o, bus.res_valid_o, bus.busy_o, bus.done_o);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_scenario1();
    load_s1();
    run_job(32'd2, 32'd180, 16'd3, 16'd3, 16'd2, 0, 0, 1'b0);
  endtask
  task automatic test_backpressure();
    load_s1();
    run_job(32'd2, 32'd180, 16'd3, 16'd3, 16'd2, 0, 5, 1'b0);
  endtask
  task automatic test_signed();
    int n;
    logic [63:0] exp_s;
    clear_mem();
    mem1[0] = 32'hFFFF_FFFE;
    mem2[0] = 32'd3;
    run_job(32'd0, 32'd0, 16'd1, 16'd0, 16'd1, 0, 0, 1'b0);
    sdat1 = 32'hFFFF_FFFE;
    sdat2 = 32'd3;
    exp_s = ext(sdat1, 1'b1) * ext(sdat2, 1'b1);
    @(negedge clk);
    bus_s.v_base_i = '0; bus_s.col_base_i = '0; bus_s.csize_i = 16'd1;
    bus_s.col_stride_i = '0; bus_s.ncols_i = 16'd1; bus_s.start_i = 1'b1;
    @(negedge clk);
    bus_s.start_i = 1'b0;
    n = 0;
    while (!bus_s.res_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus_s.res_valid_o !== 1'b1 || bus_s.res_o !== exp_s) begin
      errors++;
      $display("FAIL signed: got valid %b res %h exp valid 1 res %h", bus_s.res_valid_o, bus_s.res_o, exp_s);
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic test_zero_ncols();
    load_s1();
    run_job(32'd2, 32'd180, 16'd3, 16'd3, 16'd0, 0, 0, 1'b0);
  endtask
  task automatic test_zero_csize();
    load_s1();
    run_job(32'd2, 32'd180, 16'd0, 16'd3, 16'd2, 0, 0, 1'b0);
    run_job(32'd2, 32'd180, 16'd0, 16'd3, 16'd3, 40, 2, 1'b0);
  endtask
  task automatic test_reset_mid_run();
    load_s1();
    @(negedge clk);
    bus.v_base_i = 32'd2; bus.col_base_i = 32'd180; bus.csize_i = 16'd3;
    bus.col_stride_i = 16'd3; bus.ncols_i = 16'd2; bus.start_i = 1'b1; bus.res_ready_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.addr1_o, bus.addr2_o, bus.res_o, bus.res_col_o, bus.res_valid_o, bus.busy_o, bus.done_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: got a1 %h a2 %h res %h v %b b %b d %b exp all 0", bus.addr1_o, bus.addr2_o,
               bus.res_o, bus.res_valid_o, bus.busy_o, bus.done_o);
    end
    @(negedge clk);
    rst = 1'b0;
    run_job(32'd2, 32'd180, 16'd3, 16'd3, 16'd2, 0, 0, 1'b0);
  endtask
  task automatic test_start_while_busy();
    load_s1();
    run_job(32'd2, 32'd180, 16'd3, 16'd3, 16'd2, 0, 0, 1'b1);
  endtask
  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 256; k++) begin
        mem1[k] = $urandom;
        mem2[k] = $urandom;
      end
      run_job(32'($urandom_range(200)), 32'($urandom_range(100)), 16'($urandom_range(5)),
              16'($urandom_range(8)), 16'($urandom_range(3)), 30, int'($urandom_range(3)), t[0]);
    end
  endtask
  initial begin
    bus.start_i = 0; bus.v_base_i = '0; bus.col_base_i = '0; bus.csize_i = '0;
    bus.col_stride_i = '0; bus.ncols_i = '0; bus.res_ready_i = 1'b1;
    bus_s.start_i = 0; bus_s.v_base_i = '0; bus_s.col_base_i = '0; bus_s.csize_i = '0;
    bus_s.col_stride_i = '0; bus_s.ncols_i = '0; bus_s.res_ready_i = 1'b1;
    sdat1 = '0; sdat2 = '0;
    clear_mem();
    test_reset();
    test_scenario1();
    test_backpressure();
    test_signed();
    test_zero_ncols();
    test_zero_csize();
    test_reset_mid_run();
    test_start_while_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
